// File: rtl/adc_stream_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adc_stream_pkg                                                       |
// | Shared state encoding, default sizes and header layout for the       |
// | ADC capture stream path.                                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package adc_stream_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_HDR   = 4'b0010,
    ST_DRAIN = 4'b0100,
    ST_DONE  = 4'b1000
  } state_t;

  localparam int DEFAULT_DATA_W    = 16;
  localparam int DEFAULT_PKT_WORDS = 256;

  // Header word = {tag, sequence}; tag occupies the top bits.
  localparam int HDR_TAG_W = 4;

  function automatic int hdr_seq_w(input int data_w);
    return data_w - HDR_TAG_W;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | stream_skid2                                                         |
// | Two-entry FIFO-ordered skid buffer with occupancy and head outputs.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module stream_skid2
  import adc_stream_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head
);

  logic [DATA_W-1:0] r_d0;
  logic [DATA_W-1:0] r_d1;
  logic [1:0]        r_occ;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign w_pop_ok  = pop && (r_occ != 2'd0);
  assign w_push_ok = push && ((r_occ != 2'd2) || w_pop_ok);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_d0  <= '0;
      r_d1  <= '0;
      r_occ <= 2'd0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b11: begin
          // Simultaneous pop and push: occupancy holds, the queue shifts.
          if (r_occ == 2'd1) begin
            r_d0 <= push_data;
          end else begin
            r_d0 <= r_d1;
            r_d1 <= push_data;
          end
        end
        2'b10: begin
          if (r_occ == 2'd0) r_d0 <= push_data;
          else               r_d1 <= push_data;
          r_occ <= r_occ + 2'd1;
        end
        2'b01: begin
          r_d0  <= r_d1;
          r_occ <= r_occ - 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign occ  = r_occ;
  assign head = r_d0;

endmodule
`default_nettype wire

// File: rtl/read_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | read_controller                                                      |
// | Drains the full capture FIFO into a packetised valid/ready stream.   |
// | Optional macro HEADER_EN adds a tagged sequence header per packet.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module read_controller
  import adc_stream_pkg::*;
#(
  parameter int         DATA_W    = DEFAULT_DATA_W,
  parameter int         PKT_WORDS = DEFAULT_PKT_WORDS,
  parameter logic [3:0] HDR_TAG   = 4'hA
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              full,
  input  logic              empty,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast,
  output logic              busy,
  output logic              done,
  output logic [3:0]        state
);

  localparam int               c_idx_w    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(PKT_WORDS - 1);

`ifdef HEADER_EN
  localparam state_t c_start_state = ST_HDR;
  localparam state_t c_next_pkt    = ST_HDR;
  localparam int     c_seq_w       = hdr_seq_w(DATA_W);
`else
  localparam state_t c_start_state = ST_DRAIN;
  localparam state_t c_next_pkt    = ST_DRAIN;
`endif

  state_t               r_state;
  logic [c_idx_w-1:0]   r_word_idx;
  logic                 r_inflight;
  logic [1:0]           w_occ;
  logic [DATA_W-1:0]    w_head;
  logic                 w_rd_en;
  logic                 w_data_valid;
  logic                 w_end;
  logic                 w_last;
  logic                 w_pop;

  // Reads only from HDR/DRAIN, and never more than the skid can absorb.
  assign w_rd_en = rstn && ((r_state == ST_HDR) || (r_state == ST_DRAIN)) && !empty &&
                   (({1'b0, w_occ} + {2'b00, r_inflight}) < 3'd2);

  assign w_data_valid = (r_state == ST_DRAIN) && (w_occ != 2'd0);
  assign w_end        = empty && !r_inflight && (w_occ == 2'd1);
  assign w_last       = w_data_valid && ((r_word_idx == c_last_idx) || w_end);
  assign w_pop        = w_data_valid && m_tready;

  stream_skid2 #(
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rstn      (rstn),
    .push      (r_inflight),
    .push_data (rd_data),
    .pop       (w_pop),
    .occ       (w_occ),
    .head      (w_head)
  );

`ifdef HEADER_EN
  logic [c_seq_w-1:0] r_seq;
  logic               w_hdr_valid;

  assign w_hdr_valid = (r_state == ST_HDR);
  assign m_tvalid    = w_data_valid || w_hdr_valid;
  assign m_tdata     = w_hdr_valid ? {HDR_TAG, r_seq} : w_head;

  // Sequence runs across captures; only reset clears it.
  always_ff @(posedge clk) begin
    if (!rstn)                        r_seq <= '0;
    else if (w_hdr_valid && m_tready) r_seq <= r_seq + c_seq_w'(1);
  end
`else
  assign m_tvalid = w_data_valid;
  assign m_tdata  = w_head;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_word_idx <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_pop) r_word_idx <= w_last ? '0 : r_word_idx + c_idx_w'(1);
      case (r_state)
        ST_IDLE:  if (full) r_state <= c_start_state;
`ifdef HEADER_EN
        ST_HDR:   if (m_tready) r_state <= ST_DRAIN;
`endif
        ST_DRAIN: if (w_pop && w_last) r_state <= w_end ? ST_DONE : c_next_pkt;
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign rd_en   = w_rd_en;
  assign m_tlast = w_last;
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_read_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_read_controller                                                   |
// | Directed bench with a queue-based stream model for read_controller.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_read_controller;

  localparam int DW  = 16;
  localparam int PKT = 256;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          full = 1'b0;
  logic          empty;
  logic [DW-1:0] rd_data = '0;
  logic          rd_en;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;
  logic          m_tlast;
  logic          busy;
  logic          done;
  logic [3:0]    state;

  always #5 clk = ~clk;

  read_controller #(
    .DATA_W    (DW),
    .PKT_WORDS (PKT),
    .HDR_TAG   (4'hA)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .full     (full),
    .empty    (empty),
    .rd_data  (rd_data),
    .rd_en    (rd_en),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  // Preloaded standard-mode FIFO: word i of a capture is base+i.
  int            wr_cnt = 0;
  int            rd_ptr = 0;
  int            load_n = 0;
  logic          load_req = 1'b0;
  logic [DW-1:0] base = '0;

  assign empty = (rd_ptr >= wr_cnt);

  always @(posedge clk) begin
    if (load_req) begin
      rd_ptr <= 0;
      wr_cnt <= load_n;
    end else if (rd_en && (rd_ptr < wr_cnt)) begin
      rd_data <= base + DW'(rd_ptr);
      rd_ptr  <= rd_ptr + 1;
    end
  end

  bit rnd_ready = 1'b0;
  always @(posedge clk) begin
    #1;
    m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Expected beats: {is_header, ends_capture, tlast, data}.
  logic [DW+2:0] exq[$];
  int            total = 0;
  int            bad = 0;
  int            reads = 0;
  int            data_beats = 0;
  int            cap_beats = 0;
  int            done_cnt = 0;
  int            m_seq = 0;
  int            tlast_at[$];
  logic [DW-1:0] hdr_seen[$];
  logic [DW-1:0] last_data = '0;

  task automatic expect_capture(input int n, input logic [DW-1:0] b);
    for (int k = 0; k < n; k++) begin
`ifdef HEADER_EN
      if (k % PKT == 0) begin
        exq.push_back({1'b1, 1'b0, 1'b0, 4'hA, (DW-4)'(m_seq)});
        m_seq++;
      end
`endif
      exq.push_back({1'b0, (k == n - 1), ((k % PKT == PKT - 1) || (k == n - 1)), b + DW'(k)});
    end
  endtask

  logic          prev_stall = 1'b0;
  logic          expect_done = 1'b0;
  logic [DW-1:0] hold_d = '0;
  logic          hold_l = 1'b0;
  logic [DW+2:0] e;

  always @(negedge clk) begin
    if (!rstn) begin
      prev_stall  = 1'b0;
      expect_done = 1'b0;
      reads       = 0;
      data_beats  = 0;
      cap_beats   = 0;
    end else begin
      total++;
      if (rd_en && empty) begin
        bad++;
        $display("FAIL rd_en_empty: rd_en=%0b empty=%0b, required rd_en=0", rd_en, empty);
      end
      if (prev_stall) begin
        total++;
        if (m_tdata !== hold_d || m_tlast !== hold_l || m_tvalid !== 1'b1) begin
          bad++;
          $display("FAIL stall_hold: valid=%0b data=%h last=%0b, required valid=1 data=%h last=%0b",
                   m_tvalid, m_tdata, m_tlast, hold_d, hold_l);
        end
      end
      total++;
      if (done !== expect_done || (expect_done && state !== 4'b1000)) begin
        bad++;
        $display("FAIL done_pulse: done=%0b state=%b, required done=%0b", done, state, expect_done);
      end
      total++;
      if (busy !== (state != 4'b0001)) begin
        bad++;
        $display("FAIL busy: busy=%0b state=%b", busy, state);
      end
      if (done) done_cnt++;
      expect_done = 1'b0;
      if (m_tvalid && m_tready) begin
        total++;
        if (exq.size() == 0) begin
          bad++;
          $display("FAIL extra_beat: data=%h last=%0b, required no beat", m_tdata, m_tlast);
        end else begin
          e = exq.pop_front();
          if (m_tdata !== e[DW-1:0] || m_tlast !== e[DW]) begin
            bad++;
            $display("FAIL beat: data=%h last=%0b, required data=%h last=%0b",
                     m_tdata, m_tlast, e[DW-1:0], e[DW]);
          end
          if (e[DW+2]) begin
            hdr_seen.push_back(m_tdata);
          end else begin
            data_beats++;
            cap_beats++;
            last_data = m_tdata;
            if (m_tlast) tlast_at.push_back(cap_beats);
          end
          if (e[DW+1]) begin
            expect_done = 1'b1;
            cap_beats   = 0;
          end
        end
      end
      if (rd_en) reads++;
      total++;
      if ((reads - data_beats) > 2 || reads < data_beats) begin
        bad++;
        $display("FAIL occupancy: reads=%0d accepted=%0d, required 0..2 outstanding", reads, data_beats);
      end
      prev_stall = m_tvalid && !m_tready;
      hold_d     = m_tdata;
      hold_l     = m_tlast;
    end
  end

  task automatic check_reset_state(input string tag);
    total++;
    if (state !== 4'b0001 || rd_en !== 1'b0 || m_tvalid !== 1'b0 || m_tlast !== 1'b0 ||
        m_tdata !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL %s: state=%b rd_en=%0b tvalid=%0b tlast=%0b tdata=%h busy=%0b done=%0b, required state=0001 others 0",
               tag, state, rd_en, m_tvalid, m_tlast, m_tdata, busy, done);
    end
  endtask

  task automatic load_fifo(input int n, input logic [DW-1:0] b);
    base     = b;
    load_n   = n;
    load_req = 1'b1;
    @(posedge clk); #2;
    load_req = 1'b0;
  endtask

  task automatic start_capture(input int n, input logic [DW-1:0] b);
    bit seen;
    expect_capture(n, b);
    load_fifo(n, b);
    full = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #2;
      seen = busy;
    end
    full = 1'b0;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL start: busy=%0b state=%b after full, required busy=1", busy, state);
    end
  endtask

  task automatic run_capture(input int n, input logic [DW-1:0] b, input int budget);
    int  d0;
    bit  seen;
    d0 = done_cnt;
    start_capture(n, b);
    seen = (done_cnt > d0);
    for (int i = 0; i < budget && !seen; i++) begin
      @(posedge clk); #2;
      seen = (done_cnt > d0);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL done_timeout: done_cnt=%0d, required %0d", done_cnt, d0 + 1);
    end
  endtask

  task automatic check_tlast(input string tag, input int a, input int b, input logic [DW-1:0] last_w);
    total++;
    if (tlast_at.size() != 2 || tlast_at[0] != a || tlast_at[1] != b || last_data !== last_w ||
        exq.size() != 0) begin
      bad++;
      $display("FAIL %s: tlast_count=%0d first=%0d second=%0d last_data=%h left=%0d, required %0d/%0d last_data=%h left=0",
               tag, tlast_at.size(), (tlast_at.size() > 0) ? tlast_at[0] : -1,
               (tlast_at.size() > 1) ? tlast_at[1] : -1, last_data, exq.size(), a, b, last_w);
    end
    tlast_at.delete();
  endtask

  task automatic pulse_reset();
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_reset_state("reset_state");
    rstn = 1'b1;
    exq.delete();
    tlast_at.delete();
    hdr_seen.delete();
    m_seq = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit ok;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    check_reset_state("reset_hold");
    rstn = 1'b1;
    @(posedge clk); #2;
    check_reset_state("first_after_reset");

    // 512 words, always ready: two full packets.
    run_capture(512, 16'h0000, 3000);
    check_tlast("cap512", 256, 512, 16'd511);
    @(posedge clk); #2;
    total++;
    if (state !== 4'b0001) begin
      bad++;
      $display("FAIL idle_after_done: state=%b, required 0001", state);
    end

    // 300 words: short final packet of 44.
    run_capture(300, 16'h0400, 3000);
    check_tlast("cap300", 256, 300, 16'h052B);

    // Random backpressure.
    rnd_ready = 1'b1;
    run_capture(512, 16'h1000, 8000);
    rnd_ready = 1'b0;
    check_tlast("cap512_stall", 256, 512, 16'h11FF);

    // Empty FIFO with no full: must stay idle.
    ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (state !== 4'b0001 || rd_en !== 1'b0 || m_tvalid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL idle_hold: state=%b rd_en=%0b tvalid=%0b busy=%0b, required 0001/0/0/0",
               state, rd_en, m_tvalid, busy);
    end

    // Reset in the middle of beat 100 of packet 1, then a fresh capture.
    start_capture(512, 16'h2000);
    ok = 1'b0;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk); #2;
      ok = (cap_beats >= 99);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL reach_beat100: accepted=%0d, required 99", cap_beats);
    end
    rstn = 1'b0;
    @(posedge clk); #2;
    check_reset_state("reset_mid_packet");
    @(posedge clk); #2;
    rstn = 1'b1;
    exq.delete();
    tlast_at.delete();
    m_seq = 0;
    @(posedge clk); #2;
    check_reset_state("after_mid_reset");
    run_capture(260, 16'h3000, 3000);
    check_tlast("cap260_after_reset", 256, 260, 16'h3103);

`ifdef HEADER_EN
    // Two back-to-back captures: headers A000..A003 in order.
    pulse_reset();
    run_capture(512, 16'h4000, 3000);
    check_tlast("hdr_cap1", 256, 512, 16'h41FF);
    run_capture(512, 16'h5000, 3000);
    check_tlast("hdr_cap2", 256, 512, 16'h51FF);
    total++;
    if (hdr_seen.size() != 4 || hdr_seen[0] !== 16'hA000 || hdr_seen[1] !== 16'hA001 ||
        hdr_seen[2] !== 16'hA002 || hdr_seen[3] !== 16'hA003) begin
      bad++;
      $display("FAIL headers: count=%0d, required A000 A001 A002 A003", hdr_seen.size());
    end
`else
    pulse_reset();
`endif

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/read_controller.md
Name: read_controller

Overview:
Read-side counterpart of the ADC capture FIFO write controller. Once the writer has filled the sample FIFO (full=1), this block drains it through a standard-mode FIFO read port (1-cycle read latency). It streams samples out as an AXI-Stream-style packet stream toward the packetizer/host link. Finishes when the FIFO is empty, which releases the writer from its pause state.

Parameters:
DATA_W, 16, sample/FIFO word width in bits (>=8)
PKT_WORDS, 256, data words per packet; final packet of a capture may be shorter
HDR_TAG, 4'hA, 4-bit tag in the upper header bits (used only with HEADER_EN)

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
full  in  1  FIFO full flag
empty  in  1  FIFO empty flag
rd_data  in  DATA_W  FIFO read data, valid one cycle after rd_en
rd_en  out  1  FIFO read strobe
m_tdata  out  DATA_W  stream data
m_tvalid  out  1  stream valid
m_tready  in  1  stream ready from downstream
m_tlast  out  1  last beat of packet
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle pulse when capture drain completes
state  out  4  one-hot current state (debug)

Behaviour:
- Reset is synchronous on clk, active when rstn=0. During reset and on the first cycle after it: state=IDLE (4'b0001), rd_en=0, m_tvalid=0, m_tlast=0, m_tdata=0, busy=0, done=0.
- Reset also clears the word index, skid buffer and in-flight flag. Read data in flight during reset is discarded.
- States (one-hot): IDLE=0001, HDR=0010, DRAIN=0100, DONE=1000.
- IDLE to DRAIN when full=1. With HEADER_EN, IDLE goes to HDR instead.
- Buffering: 2-entry output skid buffer plus a 1-bit in-flight flag, set in the cycle after rd_en.
- rd_en = (state is HDR or DRAIN) && !empty && (occupancy + inflight < 2). Combinational. Never asserted when empty=1.
- The returned rd_data is written into the skid buffer on the cycle inflight=1.
- m_tvalid = DRAIN && occupancy > 0. m_tdata is the skid head word.
- A beat is accepted when m_tvalid && m_tready. Accepted words pop in FIFO order.
- m_tdata and m_tlast hold stable while m_tvalid && !m_tready.
- m_tlast = (word_idx == PKT_WORDS-1) || (empty && !inflight && occupancy == 1).
- word_idx counts accepted data beats. It wraps to 0 after a tlast beat and its width is $clog2(PKT_WORDS).
- On an accepted tlast beat:
  - if empty && !inflight && occupancy == 1, go to DONE;
  - else with HEADER_EN go to HDR;
  - else stay in DRAIN.
- DONE lasts exactly one cycle: done=1, then IDLE. Reads are never issued in DONE or IDLE.
- full=1 arriving while not in IDLE is ignored. full=1 in the DONE cycle is picked up in IDLE on the next cycle.
- Simultaneous pop and skid write in the same cycle are legal; occupancy is unchanged.

Optional Feature:
Macro HEADER_EN.
- Defined:
  - HDR state drives m_tvalid=1, m_tlast=0, m_tdata={HDR_TAG, seq[DATA_W-5:0]}.
  - Prefetch reads continue during HDR.
  - An accepted header beat moves to DRAIN and increments seq.
  - seq clears only on reset, not per capture.
  - Header beats are not counted in word_idx or PKT_WORDS.
- Undefined: no HDR logic or seq register; the HDR state encoding is reserved and never entered.

Decomposition:
- Package adc_stream_pkg holds:
  - the state enum typedef (4-bit one-hot);
  - the DEFAULT_DATA_W and DEFAULT_PKT_WORDS constants;
  - the header field-layout localparams.
- One sub-module, stream_skid2: the 2-entry skid buffer with push, pop, occupancy and head outputs.
- The FSM, rd_en and tlast logic stay in read_controller.

Test Plan:
1. FIFO preloaded with 512 incrementing words, full=1, m_tready=1, PKT_WORDS=256 -> 2 packets; m_tlast on beats 256 and 512; data 0..511 in order; done pulses once after beat 512; state returns to 0001.
2. 300 words (full forced high) -> packets of 256 and 44 beats; tlast on the 44th beat of packet 2; no extra beat.
3. 512 words with random m_tready (50%) -> no loss or duplication; m_tdata and m_tlast stable under every stall; rd_en never high while empty=1; occupancy never exceeds 2.
4. full=0, empty=1 for 100 cycles -> state stays 0001; rd_en, m_tvalid and busy stay 0.
5. rstn low during beat 100 of packet 1 -> next cycle: m_tvalid=0, rd_en=0, state=0001, done=0. A new capture after release restarts word_idx at 0.
6. HEADER_EN, two back-to-back 512-word captures -> header words A000, A001 precede the packets of capture 1; A002, A003 precede those of capture 2; headers never carry tlast.
